vga_cell_framebuffer: RTL
=========================

// Module: vga_cell_framebuffer
// PURPOSE
//  Cell-based colour framebuffer between the MiniAlu VGA instruction and the VGA timing generator.
//  The CPU writes 3-bit colours into a COLS x ROWS cell grid.
//  The display side converts the timing generator's pixel counters into cell addresses.
//  It outputs the registered pixel colour plus delayed syncs, so colour and sync stay aligned at the pins.
// PARAMETERS
//  COLS      16   cells per row
//  ROWS      12   cell rows
//  CELL_W    40   pixels per cell, horizontal
//  CELL_H    40   lines per cell, vertical
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines per frame
//  BG_COLOR  3'b000  colour written by the clear sequencer
// PORTS
//  Clock        in   1   system clock (50 MHz)
//  Reset        in   1   asynchronous, active-high
//  iPixelEn     in   1   pixel-rate enable (clk25 phase); display pipeline advances only when 1
//  iCtrH        in   11  horizontal pixel counter from VGA timing
//  iCtrV        in   11  vertical line counter from VGA timing
//  iHSync       in   1   raw hsync from VGA timing, active-low
//  iVSync       in   1   raw vsync from VGA timing, active-low
//  iWriteEnable in   1   CPU write strobe, one Clock cycle per write
//  iWriteAddr   in   8   cell index = row*COLS + col
//  iWriteData   in   3   {R,B,G} colour
//  iClear       in   1   pulse: refill every cell with BG_COLOR
//  oBusy        out  1   1 while the clear sequencer runs
//  oColor       out  3   {R,B,G} to pins
//  oHSync       out  1   hsync delayed to match oColor
//  oVSync       out  1   vsync delayed to match oColor
// BEHAVIOUR
//  Reset values:
//  - oColor = 0; oHSync = oVSync = 1; oBusy = 1.
//  - FSM enters CLEAR, address counter = 0, all pipeline registers = 0 / sync 1.
//  - Cell RAM contents are not reset; CLEAR initialises them.
//  FSM:
//  - CLEAR: each Clock cycle writes BG_COLOR to cell clr_addr, then clr_addr++.
//  - After writing address COLS*ROWS-1 (191), CLEAR -> RUN next cycle; a clear takes exactly 192 cycles.
//  - While in CLEAR, CPU writes are dropped and oBusy = 1.
//  - RUN: oBusy = 0; CPU writes accepted.
//  - iClear = 1 in RUN -> CLEAR with clr_addr = 0.
//  - iClear while already in CLEAR is ignored (no restart).
//  - Async Reset mid-clear restarts CLEAR from address 0.
//  CPU writes:
//  - Accepted when iWriteEnable = 1, state = RUN and iWriteAddr < COLS*ROWS.
//  - Addresses 192..255 are ignored with no side effect. No acknowledge; fire-and-forget.
//  Cell mapping: counters only, no dividers.
//  - col/xsub: when iCtrH == 0, col = 0 and xsub = 0; otherwise xsub++.
//  - When xsub reaches CELL_W-1, xsub = 0 and col++.
//  - row/ysub advance on the pixel-enabled cycle where iCtrH == 0 and iCtrV != 0.
//  - When iCtrV == 0, row = ysub = 0. ysub wraps at CELL_H-1, then row++.
//  - active = (iCtrH < H_ACTIVE) && (iCtrV < V_ACTIVE).
//  Display pipeline: advances only on Clock edges with iPixelEn = 1.
//  - Stage 1 registers addr = row*COLS + col (shift-add), active, iHSync and iVSync.
//  - Stage 2 reads the RAM synchronously and registers oColor = active_d ? ram[addr] : 3'b000.
//  - Syncs pass through the same 2 stages.
//  - Latency: 2 pixel-enabled cycles from counters to oColor/oHSync/oVSync.
//  - Outputs hold their values when iPixelEn = 0.
//  Collisions:
//  - A write and a display read to the same cell in the same cycle: the read returns the OLD data; the new value is visible from the next read.
//  - Blanking: oColor is forced to 0 whenever active is 0, regardless of RAM contents.
// TESTING
//  T1: Reset 3 cycles, release -> oBusy = 1 for exactly 192 Clock cycles, then 0. Every cell reads BG_COLOR.
//  T2: In RUN, write addr 17 (row1 col1) = 3'b100.
//      -> Pixels H 40..79, V 40..79 give oColor = 3'b100, 2 pixel-enables after the counters.
//      -> Pixel (39,40) gives 0.
//  T3: Write addr 200 = 3'b111 -> no cell changes; full-frame scan is identical to before.
//  T4: Fill all cells with 3'b011, drive H = 640..799, V = 0 -> oColor = 0.
//      -> oHSync follows iHSync delayed by 2 pixel-enables.
//  T5: Display reading cell 5 while the CPU writes 3'b010 to cell 5 in the same cycle -> old colour on that pixel, 3'b010 on the next pixel of cell 5.
//  T6: iClear in RUN, assert Reset at clear cycle 100 -> clear restarts and oBusy stays 1 for 192 cycles after release.
//      -> A CPU write during CLEAR is dropped.

Source files
------------

// File: rtl/vga_cell_framebuffer.sv
// Cell-grid colour framebuffer: CPU writes 3-bit cell colours, the display side maps VGA counters to cells.
// Two pixel-enabled stages from counters to pins; a clear sequencer refills the grid after reset or on request.
module vga_cell_framebuffer #(
    parameter int         COLS     = 16,
    parameter int         ROWS     = 12,
    parameter int         CELL_W   = 40,
    parameter int         CELL_H   = 40,
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iPixelEn,
    input  logic [10:0] iCtrH,
    input  logic [10:0] iCtrV,
    input  logic        iHSync,
    input  logic        iVSync,
    input  logic        iWriteEnable,
    input  logic [7:0]  iWriteAddr,
    input  logic [2:0]  iWriteData,
    input  logic        iClear,
    output logic        oBusy,
    output logic [2:0]  oColor,
    output logic        oHSync,
    output logic        oVSync
);

    localparam int         NCELLS    = COLS * ROWS;
    localparam logic [7:0] LAST_ADDR = 8'(NCELLS - 1);
    localparam logic [7:0] NCELLS8   = 8'(NCELLS);
    localparam int         COL_SH    = $clog2(COLS);
    localparam logic [5:0] X_LAST    = 6'(CELL_W - 1);
    localparam logic [5:0] Y_LAST    = 6'(CELL_H - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  clr_addr;
    logic        clear_we, cpu_we;
    logic [2:0]  ram [NCELLS];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_RUN;
            S_RUN:   if (iClear) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        clear_we = (state == S_CLEAR);
        cpu_we   = (state == S_RUN) && iWriteEnable && (iWriteAddr < NCELLS8);
    end

    assign oBusy = clear_we;

    // Held at zero outside CLEAR so a clear requested from RUN always starts at cell 0.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                 clr_addr <= '0;
        else if (state == S_CLEAR) clr_addr <= clr_addr + 8'd1;
        else                       clr_addr <= '0;
    end

    always_ff @(posedge Clock) begin
        if (clear_we)    ram[clr_addr]   <= BG_COLOR;
        else if (cpu_we) ram[iWriteAddr] <= iWriteData;
    end

    // Cell coordinates of the current pixel, derived from the previous pixel's counters.
    logic [7:0] col_q, col_n, row_q, row_n;
    logic [5:0] xsub_q, xsub_n, ysub_q, ysub_n;
    logic [7:0] addr_n, addr_d;
    logic       active_n, active_d, hs_d, vs_d;

    always_comb begin
        col_n  = col_q;
        xsub_n = xsub_q;
        row_n  = row_q;
        ysub_n = ysub_q;
        if (iCtrH == 11'd0) begin
            col_n  = '0;
            xsub_n = '0;
        end else if (xsub_q == X_LAST) begin
            xsub_n = '0;
            col_n  = col_q + 8'd1;
        end else begin
            xsub_n = xsub_q + 6'd1;
        end
        if (iCtrV == 11'd0) begin
            row_n  = '0;
            ysub_n = '0;
        end else if (iCtrH == 11'd0) begin
            if (ysub_q == Y_LAST) begin
                ysub_n = '0;
                row_n  = row_q + 8'd1;
            end else begin
                ysub_n = ysub_q + 6'd1;
            end
        end
    end

    assign addr_n   = (row_n << COL_SH) + col_n;
    assign active_n = (iCtrH < H_ACT) && (iCtrV < V_ACT);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_q    <= '0;
            xsub_q   <= '0;
            row_q    <= '0;
            ysub_q   <= '0;
            addr_d   <= '0;
            active_d <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
        end else if (iPixelEn) begin
            col_q    <= col_n;
            xsub_q   <= xsub_n;
            row_q    <= row_n;
            ysub_q   <= ysub_n;
            addr_d   <= addr_n;
            active_d <= active_n;
            hs_d     <= iHSync;
            vs_d     <= iVSync;
        end
    end

    // The read sees pre-write contents when a CPU write lands on the same edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oColor <= 3'b000;
            oHSync <= 1'b1;
            oVSync <= 1'b1;
        end else if (iPixelEn) begin
            oColor <= active_d ? ram[addr_d] : 3'b000;
            oHSync <= hs_d;
            oVSync <= vs_d;
        end
    end

endmodule
